vocab_matcher: RTL and testbench

- Scans a vocabulary memory of consecutive null-terminated words for a null-terminated query word held in a second memory.
- Reports hit/miss, the token index of the hit and the start address of the matching entry.
- Sits between the tokenizer front end and the embedding lookup.
- Generalised over width and depth, with runtime vocab bounds, optional ASCII case folding, start/done handshake and abort.

---
 rtl/vocab_matcher_pkg.sv | 19 +
 rtl/vocab_matcher_if.sv | 39 +++
 rtl/vocab_matcher_char_fold.sv | 15 +
 rtl/vocab_matcher.sv | 166 ++++++++++++++++
 tb/tb_vocab_matcher.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/vocab_matcher_pkg.sv
// Shared types and constants for the vocabulary matcher: FSM states,
// the string terminator and the ASCII upper-case range folded to lower case.
package vocab_matcher_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CMP,
    S_SKIP_RD,
    S_SKIP_CHK,
    S_DONE
  } state_e;

  localparam int unsigned NUL        = 'h00;
  localparam int unsigned FOLD_LO    = 'h41;
  localparam int unsigned FOLD_HI    = 'h5A;
  localparam int unsigned FOLD_DELTA = 'h20;

endpackage

// File: rtl/vocab_matcher_if.sv
// Control, memory-port and result signals of the vocabulary matcher,
// grouped so the block drops between tokenizer and embedding lookup as one bundle.
interface vocab_matcher_if #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned TOKEN_WIDTH = 7
);
  logic                   start;
  logic                   abort;
  logic                   case_fold;
  logic [ADDR_WIDTH-1:0]  vocab_base;
  logic [ADDR_WIDTH-1:0]  vocab_limit;
  logic [ADDR_WIDTH-1:0]  query_base;
  logic [ADDR_WIDTH-1:0]  vocab_addr;
  logic                   vocab_rd_en;
  logic [DATA_WIDTH-1:0]  vocab_rdata;
  logic [ADDR_WIDTH-1:0]  query_addr;
  logic                   query_rd_en;
  logic [DATA_WIDTH-1:0]  query_rdata;
  logic                   busy;
  logic                   done;
  logic                   found;
  logic [TOKEN_WIDTH-1:0] token_id;
  logic [ADDR_WIDTH-1:0]  match_addr;

  modport slave (
    input  start, abort, case_fold, vocab_base, vocab_limit, query_base,
           vocab_rdata, query_rdata,
    output vocab_addr, vocab_rd_en, query_addr, query_rd_en,
           busy, done, found, token_id, match_addr
  );

  modport master (
    output start, abort, case_fold, vocab_base, vocab_limit, query_base,
           vocab_rdata, query_rdata,
    input  vocab_addr, vocab_rd_en, query_addr, query_rd_en,
           busy, done, found, token_id, match_addr
  );
endinterface

// File: rtl/vocab_matcher_char_fold.sv
// Combinational ASCII case fold: maps 'A'..'Z' to 'a'..'z' when enabled.
module char_fold #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_char,
  output logic [DATA_WIDTH-1:0] o_char
);
  import vocab_matcher_pkg::*;

  logic w_upper;

  assign w_upper = (i_char >= DATA_WIDTH'(FOLD_LO)) && (i_char <= DATA_WIDTH'(FOLD_HI));
  assign o_char  = (i_en && w_upper) ? i_char + DATA_WIDTH'(FOLD_DELTA) : i_char;
endmodule

// File: rtl/vocab_matcher.sv
// Scans a vocabulary of null-terminated words for a null-terminated query,
// reporting hit/miss, the token index and the start address of the matching entry.
module vocab_matcher #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned TOKEN_WIDTH = 7
) (
  input logic         clk,
  input logic         rst_n,
  vocab_matcher_if.slave bus
);
  import vocab_matcher_pkg::*;

  state_e                 r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_av, w_av_nxt;
  logic [ADDR_WIDTH-1:0]  r_ai, w_ai_nxt;
  logic [ADDR_WIDTH-1:0]  r_ws, w_ws_nxt;
  logic [ADDR_WIDTH-1:0]  r_qbase, w_qbase_nxt;
  logic [ADDR_WIDTH-1:0]  r_limit, w_limit_nxt;
  logic                   r_fold, w_fold_nxt;
  logic [TOKEN_WIDTH-1:0] r_tok, w_tok_nxt;
  logic                   r_found, w_found_nxt;
  logic [TOKEN_WIDTH-1:0] r_token_id, w_token_id_nxt;
  logic [ADDR_WIDTH-1:0]  r_match_addr, w_match_addr_nxt;

  logic [DATA_WIDTH-1:0]  w_v, w_q;
  logic [ADDR_WIDTH-1:0]  w_av_inc;
  logic                   w_end, w_v_nul, w_q_nul;
  logic                   w_hit, w_miss, w_next_word;

  char_fold #(.DATA_WIDTH(DATA_WIDTH)) u_fold_v (.i_en(r_fold), .i_char(bus.vocab_rdata), .o_char(w_v));
  char_fold #(.DATA_WIDTH(DATA_WIDTH)) u_fold_q (.i_en(r_fold), .i_char(bus.query_rdata), .o_char(w_q));

  assign w_av_inc = r_av + ADDR_WIDTH'(1);
  assign w_end    = (r_av == r_limit);
  assign w_v_nul  = (w_v == DATA_WIDTH'(NUL));
  assign w_q_nul  = (w_q == DATA_WIDTH'(NUL));

  always_comb begin
    w_state_nxt      = r_state;
    w_av_nxt         = r_av;
    w_ai_nxt         = r_ai;
    w_ws_nxt         = r_ws;
    w_qbase_nxt      = r_qbase;
    w_limit_nxt      = r_limit;
    w_fold_nxt       = r_fold;
    w_tok_nxt        = r_tok;
    w_found_nxt      = r_found;
    w_token_id_nxt   = r_token_id;
    w_match_addr_nxt = r_match_addr;
    w_hit            = 1'b0;
    w_miss           = 1'b0;
    w_next_word      = 1'b0;

    if (r_state != S_IDLE && bus.abort) begin
      w_state_nxt = S_IDLE;
      w_found_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.start) begin
          w_av_nxt    = bus.vocab_base;
          w_ws_nxt    = bus.vocab_base;
          w_ai_nxt    = bus.query_base;
          w_qbase_nxt = bus.query_base;
          w_limit_nxt = bus.vocab_limit;
          w_fold_nxt  = bus.case_fold;
          w_tok_nxt   = '0;
          w_found_nxt = 1'b0;
          w_state_nxt = S_RD;
        end
        S_RD:      w_state_nxt = S_CMP;
        S_SKIP_RD: w_state_nxt = S_SKIP_CHK;
        // Rule order matters: empty query, then full match, then mismatch cases.
        S_CMP: begin
          if (r_ai == r_qbase && w_q_nul) begin
            w_miss = 1'b1;
          end else if (w_v == w_q) begin
            if (w_q_nul)    w_hit  = 1'b1;
            else if (w_end) w_miss = 1'b1;
            else begin
              w_av_nxt    = w_av_inc;
              w_ai_nxt    = r_ai + ADDR_WIDTH'(1);
              w_state_nxt = S_RD;
            end
          end else if (w_v_nul) begin
            if (r_av == r_ws || w_end) w_miss      = 1'b1;
            else                       w_next_word = 1'b1;
          end else if (w_end) begin
            w_miss = 1'b1;
          end else begin
            w_av_nxt    = w_av_inc;
            w_state_nxt = S_SKIP_RD;
          end
        end
        S_SKIP_CHK: begin
          if (w_end) begin
            w_miss = 1'b1;
          end else if (w_v_nul) begin
            w_next_word = 1'b1;
          end else begin
            w_av_nxt    = w_av_inc;
            w_state_nxt = S_SKIP_RD;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase

      if (w_next_word) begin
        w_ws_nxt    = w_av_inc;
        w_av_nxt    = w_av_inc;
        w_tok_nxt   = r_tok + TOKEN_WIDTH'(1);
        w_ai_nxt    = r_qbase;
        w_state_nxt = S_RD;
      end
      if (w_hit) begin
        w_found_nxt      = 1'b1;
        w_token_id_nxt   = r_tok;
        w_match_addr_nxt = r_ws;
        w_state_nxt      = S_DONE;
      end
      if (w_miss) begin
        w_found_nxt = 1'b0;
        w_state_nxt = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_av         <= '0;
      r_ai         <= '0;
      r_ws         <= '0;
      r_qbase      <= '0;
      r_limit      <= '0;
      r_fold       <= 1'b0;
      r_tok        <= '0;
      r_found      <= 1'b0;
      r_token_id   <= '0;
      r_match_addr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_av         <= w_av_nxt;
      r_ai         <= w_ai_nxt;
      r_ws         <= w_ws_nxt;
      r_qbase      <= w_qbase_nxt;
      r_limit      <= w_limit_nxt;
      r_fold       <= w_fold_nxt;
      r_tok        <= w_tok_nxt;
      r_found      <= w_found_nxt;
      r_token_id   <= w_token_id_nxt;
      r_match_addr <= w_match_addr_nxt;
    end
  end

  assign bus.vocab_addr  = r_av;
  assign bus.query_addr  = r_ai;
  assign bus.vocab_rd_en = (r_state == S_RD) || (r_state == S_SKIP_RD);
  assign bus.query_rd_en = (r_state == S_RD);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.found       = r_found;
  assign bus.token_id    = r_token_id;
  assign bus.match_addr  = r_match_addr;
endmodule

// File: tb/tb_vocab_matcher.sv
// Directed bench for vocab_matcher: fixed vocabulary "at\0cat\0dog\0\0" with
// 1-cycle-latency memory models and hand-computed results.
module tb_vocab_matcher;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [7:0] vmem [256];
  logic [7:0] qmem [256];

  vocab_matcher_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TOKEN_WIDTH(7)) bus ();

  vocab_matcher #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TOKEN_WIDTH(7)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.vocab_rd_en) bus.vocab_rdata <= vmem[bus.vocab_addr];
    if (bus.query_rd_en) bus.query_rdata <= qmem[bus.query_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_query(input logic [7:0] base, input string s);
    for (int i = 0; i < s.len(); i++) qmem[8'(base + i)] = s[i];
    qmem[8'(base + s.len())] = 8'h00;
  endtask

  // Start is sampled on the first edge (cycle 0 ends there); done_cyc is the
  // cycle in which done is observed, counting that start edge as the end of cycle 0.
  task automatic run(input logic fold, input logic [7:0] limit, input logic [7:0] qbase,
                     output int done_cyc, output logic got_done, output int vmax);
    bus.case_fold   = fold;
    bus.vocab_base  = 8'd0;
    bus.vocab_limit = limit;
    bus.query_base  = qbase;
    bus.start       = 1'b1;
    got_done = 1'b0;
    done_cyc = 0;
    vmax     = 0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    if (bus.vocab_rd_en && int'(bus.vocab_addr) > vmax) vmax = int'(bus.vocab_addr);
    for (int c = 1; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        got_done = 1'b1;
        done_cyc = c + 1;
        break;
      end
      if (bus.vocab_rd_en && int'(bus.vocab_addr) > vmax) vmax = int'(bus.vocab_addr);
    end
    if (got_done) begin
      @(posedge clk);
      #1 check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    end
  endtask

  int   dcyc;
  int   vmax;
  logic gdone;
  logic saw_done;
  logic [7:0] vinit [12];

  initial begin
    n_checks = 0;
    n_errors = 0;
    vinit = '{8'h61, 8'h74, 8'h00, 8'h63, 8'h61, 8'h74, 8'h00, 8'h64, 8'h6F, 8'h67, 8'h00, 8'h00};
    for (int i = 0; i < 256; i++) begin
      vmem[i] = 8'h7E;
      qmem[i] = 8'h00;
    end
    for (int i = 0; i < 12; i++) vmem[i] = vinit[i];
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.case_fold = 1'b0;
    bus.vocab_base = '0; bus.vocab_limit = '0; bus.query_base = '0;
    bus.vocab_rdata = '0; bus.query_rdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);
    check("rst_found", {31'd0, bus.found}, 32'd0);
    check("rst_rden",  {30'd0, bus.vocab_rd_en, bus.query_rd_en}, 32'd0);
    check("rst_addr",  {16'd0, bus.vocab_addr, bus.query_addr}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    load_query(8'd0, "at");
    run(1'b0, 8'd15, 8'd0, dcyc, gdone, vmax);
    check("at_done",  {31'd0, gdone}, 32'd1);
    check("at_cycle", dcyc, 32'd7);
    check("at_found", {31'd0, bus.found}, 32'd1);
    check("at_tok",   {25'd0, bus.token_id}, 32'd0);
    check("at_addr",  {24'd0, bus.match_addr}, 32'd0);

    load_query(8'd32, "cat");
    run(1'b0, 8'd15, 8'd32, dcyc, gdone, vmax);
    check("cat_found", {31'd0, bus.found}, 32'd1);
    check("cat_tok",   {25'd0, bus.token_id}, 32'd1);
    check("cat_addr",  {24'd0, bus.match_addr}, 32'd3);

    load_query(8'd0, "dog");
    run(1'b0, 8'd15, 8'd0, dcyc, gdone, vmax);
    check("dog_found", {31'd0, bus.found}, 32'd1);
    check("dog_tok",   {25'd0, bus.token_id}, 32'd2);
    check("dog_addr",  {24'd0, bus.match_addr}, 32'd7);

    load_query(8'd0, "ca");
    run(1'b0, 8'd15, 8'd0, dcyc, gdone, vmax);
    check("ca_done",  {31'd0, gdone}, 32'd1);
    check("ca_found", {31'd0, bus.found}, 32'd0);
    check("ca_tok_hold",  {25'd0, bus.token_id}, 32'd2);
    check("ca_addr_hold", {24'd0, bus.match_addr}, 32'd7);

    load_query(8'd0, "cow");
    run(1'b0, 8'd15, 8'd0, dcyc, gdone, vmax);
    check("cow_found", {31'd0, bus.found}, 32'd0);
    check("cow_vmax",  vmax, 32'd11);

    load_query(8'd0, "CAT");
    run(1'b1, 8'd15, 8'd0, dcyc, gdone, vmax);
    check("CAT_fold_found", {31'd0, bus.found}, 32'd1);
    check("CAT_fold_tok",   {25'd0, bus.token_id}, 32'd1);
    run(1'b0, 8'd15, 8'd0, dcyc, gdone, vmax);
    check("CAT_nofold_found", {31'd0, bus.found}, 32'd0);

    load_query(8'd0, "dog");
    run(1'b0, 8'd5, 8'd0, dcyc, gdone, vmax);
    check("lim_done",  {31'd0, gdone}, 32'd1);
    check("lim_found", {31'd0, bus.found}, 32'd0);
    check("lim_vmax",  vmax, 32'd5);

    load_query(8'd40, "");
    run(1'b0, 8'd15, 8'd40, dcyc, gdone, vmax);
    check("empty_cycle", dcyc, 32'd3);
    check("empty_found", {31'd0, bus.found}, 32'd0);

    // Abort while the vocab-only read of a skip is in progress.
    load_query(8'd0, "dog");
    bus.vocab_limit = 8'd15; bus.query_base = 8'd0; bus.case_fold = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    gdone = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.vocab_rd_en && !bus.query_rd_en) begin
        gdone = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("abort_reach_skip", {31'd0, gdone}, 32'd1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    check("abort_busy",  {31'd0, bus.busy}, 32'd0);
    check("abort_done",  {31'd0, bus.done}, 32'd0);
    check("abort_found", {31'd0, bus.found}, 32'd0);
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 if (bus.done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);

    load_query(8'd0, "cat");
    run(1'b0, 8'd15, 8'd0, dcyc, gdone, vmax);
    check("post_abort_found", {31'd0, bus.found}, 32'd1);
    check("post_abort_tok",   {25'd0, bus.token_id}, 32'd1);

    // Reset in the middle of a scan clears everything at once.
    load_query(8'd0, "dog");
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_busy",  {31'd0, bus.busy}, 32'd0);
    check("rstmid_found", {31'd0, bus.found}, 32'd0);
    check("rstmid_tok",   {25'd0, bus.token_id}, 32'd0);
    check("rstmid_addr",  {24'd0, bus.match_addr}, 32'd0);
    check("rstmid_vaddr", {24'd0, bus.vocab_addr}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
